// File: rtl/scsi_pkg.sv
// Shared definitions for the SCSI host transmit path: state encoding,
// idle/reset constants and a small helper used by the top level.
package scsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } scsi_state_t;

  // Value presented on nDBOut whenever the bus is not being driven.
  localparam logic [7:0] BUS_IDLE     = 8'h00;
  // Inactive level of the active-low SCSI control lines.
  localparam logic       SIG_INACTIVE = 1'b1;
  // Data register contents after reset.
  localparam logic [7:0] DATA_RESET   = 8'h00;
  // Width of the setup-time counter.
  localparam int unsigned SETUP_CNT_W = 4;

  // True in the states where the data byte is placed on the bus.
  function automatic logic drives_bus(input scsi_state_t s);
    return (s == ST_SETUP) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/scsi_sync.sv
// Multi-flop synchroniser for one asynchronous SCSI control line.
// Resets to the inactive (high) level so nothing looks asserted out of reset.
module scsi_sync
  import scsi_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input into the chain; the oldest bit is the output.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops, forced inactive by reset.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sync_q <= {STAGES{SIG_INACTIVE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/scsi_host_tx.sv
// SCSI host transmit engine: takes one byte from the host, waits for an
// initiator-to-target REQ, presents the byte for a fixed setup time, then
// runs the REQ/ACK handshake and releases the bus.
//
// Handshake: a host write (nWrite low for one clock) is accepted only in
// IDLE; any other write is dropped and flags overrun. On the SCSI side the
// byte is driven while SETUP/ACK, nACK falls after SETUP_CYCLES clocks of
// setup and rises once the synchronised REQ is seen deasserted.
// SETUP_CYCLES must lie in 1..15 (4-bit counter); SYNC_STAGES must be >= 2.
module scsi_host_tx
  import scsi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SETUP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic [7:0] hostData,
  input  logic       nWrite,
  input  logic       clrOverrun,
  input  logic       nREQ,
  input  logic       nIO,
  output logic       nACK,
  output logic [7:0] nDBOut,
  output logic       dbDrive,
  output logic       busy,
  output logic       overrun
);

  // Counter is loaded with SETUP_CYCLES-1 and counts down to zero, so the
  // block spends exactly SETUP_CYCLES clocks in SETUP.
  localparam logic [SETUP_CNT_W-1:0] SETUP_LOAD = SETUP_CNT_W'(SETUP_CYCLES - 1);

  logic s_req;
  logic s_io;

  scsi_state_t            state_q, state_d;
  logic [SETUP_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   overrun_q, overrun_d;
  logic                   nack_q, nack_d;
  logic                   drive_q, drive_d;
  logic [7:0]             ndb_q, ndb_d;
  logic                   write_req;
  logic                   write_reject;

  scsi_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clock  (clock),
    .nReset (nReset),
    .d      (nREQ),
    .q      (s_req)
  );

  scsi_sync #(.STAGES(SYNC_STAGES)) u_sync_io (
    .clock  (clock),
    .nReset (nReset),
    .d      (nIO),
    .q      (s_io)
  );

  // Next-state, data register, setup counter and overrun logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    write_req    = !nWrite;
    write_reject = write_req && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (write_req) begin
          data_d  = hostData;
          state_d = ST_LOADED;
        end
      end
      ST_LOADED: begin
        // Only an out-phase REQ starts the transfer; a wrong phase just waits.
        if (!s_req && s_io) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        // Phase changes here are ignored; only REQ release ends the cycle.
        if (s_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A rejected write wins over a simultaneous clear.
    if (write_reject) begin
      overrun_d = 1'b1;
    end else if (clrOverrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    nack_d  = !(state_d == ST_ACK);
    drive_d = drives_bus(state_d);
    ndb_d   = drive_d ? ~data_d : BUS_IDLE;
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= DATA_RESET;
      overrun_q <= 1'b0;
      nack_q    <= SIG_INACTIVE;
      drive_q   <= 1'b0;
      ndb_q     <= BUS_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      nack_q    <= nack_d;
      drive_q   <= drive_d;
      ndb_q     <= ndb_d;
    end
  end

  assign nACK    = nack_q;
  assign nDBOut  = ndb_q;
  assign dbDrive = drive_q;
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_scsi_host_tx.sv
// Bench for scsi_host_tx: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a transaction
// level model of the host-to-SCSI transfer.
module tb_scsi_host_tx;

  localparam int SYNC_STAGES  = 2;
  localparam int SETUP_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic       clock      = 1'b0;
  logic       nReset     = 1'b0;
  logic [7:0] hostData   = 8'h00;
  logic       nWrite     = 1'b1;
  logic       clrOverrun = 1'b0;
  logic       nREQ       = 1'b1;
  logic       nIO        = 1'b1;
  logic       nACK;
  logic [7:0] nDBOut;
  logic       dbDrive;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  scsi_host_tx #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SETUP_CYCLES (SETUP_CYCLES)
  ) dut (
    .clock      (clock),
    .nReset     (nReset),
    .hostData   (hostData),
    .nWrite     (nWrite),
    .clrOverrun (clrOverrun),
    .nREQ       (nREQ),
    .nIO        (nIO),
    .nACK       (nACK),
    .nDBOut     (nDBOut),
    .dbDrive    (dbDrive),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of one byte's journey: waiting for a byte, holding a byte,
  // counting setup time, acknowledging, one release clock.
  localparam int P_IDLE    = 0;
  localparam int P_HOLD    = 1;
  localparam int P_SETUP   = 2;
  localparam int P_ACK     = 3;
  localparam int P_RELEASE = 4;

  int         m_phase = P_IDLE;
  int         m_left  = 0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovr   = 1'b0;
  logic       m_req_pipe[$];
  logic       m_io_pipe[$];

  always @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      m_phase = P_IDLE;
      m_left  = 0;
      m_data  = 8'h00;
      m_ovr   = 1'b0;
      m_req_pipe.delete();
      m_io_pipe.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        m_req_pipe.push_back(1'b1);
        m_io_pipe.push_back(1'b1);
      end
    end else begin
      logic sreq;
      logic sio;
      logic rejected;
      sreq = m_req_pipe[0];
      sio  = m_io_pipe[0];
      void'(m_req_pipe.pop_front());
      void'(m_io_pipe.pop_front());
      m_req_pipe.push_back(nREQ);
      m_io_pipe.push_back(nIO);

      rejected = !nWrite && (m_phase != P_IDLE);
      if (rejected) m_ovr = 1'b1;
      else if (clrOverrun) m_ovr = 1'b0;

      case (m_phase)
        P_IDLE: if (!nWrite) begin m_data = hostData; m_phase = P_HOLD; end
        P_HOLD: if (!sreq && sio) begin m_phase = P_SETUP; m_left = SETUP_CYCLES; end
        P_SETUP: begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = P_ACK;
        end
        P_ACK: if (sreq) m_phase = P_RELEASE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    logic       e_drv;
    logic [7:0] e_db;
    e_drv = (m_phase == P_SETUP) || (m_phase == P_ACK);
    e_db  = e_drv ? ~m_data : 8'h00;
    chk("cmp_nACK",    32'(nACK),    32'(m_phase != P_ACK));
    chk("cmp_dbDrive", 32'(dbDrive), 32'(e_drv));
    chk("cmp_nDBOut",  32'(nDBOut),  32'(e_db));
    chk("cmp_busy",    32'(busy),    32'(m_phase != P_IDLE));
    chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    nWrite   = 1'b0;
    hostData = b;
    cyc();
    nWrite   = 1'b1;
  endtask

  task automatic wait_nack(input logic level, input string name);
    for (int i = 0; i < 40; i++) begin
      if (nACK === level) break;
      cyc();
    end
    chk(name, 32'(nACK), 32'(level));
  endtask

  task automatic wait_drive(input string name);
    for (int i = 0; i < 40; i++) begin
      if (dbDrive === 1'b1) break;
      cyc();
    end
    chk(name, 32'(dbDrive), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) break;
      cyc();
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Completes a transfer whose byte is already loaded, with out phase.
  task automatic finish_xfer(input logic [7:0] exp_db, input string name);
    nIO  = 1'b1;
    nREQ = 1'b0;
    wait_drive({name, "_drive"});
    chk({name, "_db"}, 32'(nDBOut), 32'(exp_db));
    wait_nack(1'b0, {name, "_ack"});
    nREQ = 1'b1;
    wait_idle({name, "_idle"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    logic got;
    logic last_wr;

    // Reset state
    repeat (3) cyc();
    chk("rst_nACK",    32'(nACK),    32'd1);
    chk("rst_dbDrive", 32'(dbDrive), 32'd0);
    chk("rst_nDBOut",  32'(nDBOut),  32'h00);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    nReset = 1'b1;
    cyc();

    // Normal transfer: A5 with REQ already low, out phase
    nIO  = 1'b1;
    nREQ = 1'b0;
    repeat (3) cyc();
    nWrite   = 1'b0;
    hostData = 8'hA5;
    n   = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      cyc();
      nWrite = 1'b1;
      if (i == 2) begin
        chk("norm_setup_drive", 32'(dbDrive), 32'd1);
        chk("norm_setup_db",    32'(nDBOut),  32'h5A);
      end
      if (nACK === 1'b0) begin
        got = 1'b1;
        n   = i;
      end
    end
    chk("norm_ack_latency", 32'(n), 32'd6);
    nREQ = 1'b1;
    wait_nack(1'b1, "norm_ack_release");
    chk("norm_release_busy",  32'(busy),    32'd1);
    chk("norm_release_drive", 32'(dbDrive), 32'd0);
    cyc();
    chk("norm_idle_busy", 32'(busy), 32'd0);

    // Overrun: second write while LOADED is dropped
    write_byte(8'h11);
    cyc();
    write_byte(8'h22);
    chk("ovr_set", 32'(overrun), 32'd1);
    finish_xfer(8'hEE, "ovr_xfer");

    // Overrun precedence
    clrOverrun = 1'b1;
    cyc();
    clrOverrun = 1'b0;
    chk("ovr_clr_alone_a", 32'(overrun), 32'd0);
    write_byte(8'h33);
    nWrite     = 1'b0;
    hostData   = 8'h44;
    clrOverrun = 1'b1;
    cyc();
    nWrite     = 1'b1;
    clrOverrun = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    clrOverrun = 1'b1;
    cyc();
    clrOverrun = 1'b0;
    chk("ovr_clr_alone_b", 32'(overrun), 32'd0);
    finish_xfer(8'hCC, "prec_xfer");

    // Wrong phase: REQ low but in phase, byte must wait
    nIO  = 1'b0;
    nREQ = 1'b0;
    repeat (3) cyc();
    write_byte(8'h3C);
    repeat (6) cyc();
    chk("phase_busy",  32'(busy),    32'd1);
    chk("phase_drive", 32'(dbDrive), 32'd0);
    chk("phase_db",    32'(nDBOut),  32'h00);
    chk("phase_nack",  32'(nACK),    32'd1);
    finish_xfer(8'hC3, "phase_xfer");

    // Randomized traffic, checked by the scoreboard every cycle
    last_wr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      nWrite     = (last_wr || ($urandom_range(0, 7) != 0)) ? 1'b1 : 1'b0;
      last_wr    = !nWrite;
      hostData   = 8'($urandom());
      clrOverrun = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) nREQ = ~nREQ;
      if ($urandom_range(0, 9) == 0) nIO  = ~nIO;
      cyc();
    end
    nWrite     = 1'b1;
    clrOverrun = 1'b0;

    // Reset in the middle of ACK releases everything without a clock edge
    nReset = 1'b0;
    repeat (2) cyc();
    nReset = 1'b1;
    nREQ   = 1'b0;
    nIO    = 1'b1;
    repeat (3) cyc();
    write_byte(8'h5A);
    wait_nack(1'b0, "midack_reach_ack");
    #2;
    nReset = 1'b0;
    #1;
    chk("midack_nACK",    32'(nACK),    32'd1);
    chk("midack_dbDrive", 32'(dbDrive), 32'd0);
    chk("midack_nDBOut",  32'(nDBOut),  32'h00);
    chk("midack_busy",    32'(busy),    32'd0);
    cyc();
    nReset = 1'b1;
    repeat (4) cyc();
    chk("midack_no_resume_busy", 32'(busy), 32'd0);
    chk("midack_no_resume_nack", 32'(nACK), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scsi_host_tx.md
SCSI_HOST_TX -- requirements
Module: scsi_host_tx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on nREQ and nIO (minimum 2).
REQ-002 SHALL have parameter SETUP_CYCLES, default 4: clocks of data setup on the bus before nACK falls (range 1..15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all other timing is relative to the rising edge of clock.
REQ-004 clock  input  1  system clock.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 hostData  input  8  host write data; sampled on the clock where nWrite is low.
REQ-007 nWrite  input  1  host data-register write strobe, active-low, synchronous, one clock wide per write.
REQ-008 clrOverrun  input  1  synchronous clear of overrun, active-high.
REQ-009 nREQ  input  1  SCSI REQ, active-low, asynchronous to clock.
REQ-010 nIO  input  1  SCSI I/O, asynchronous; high = initiator-to-target (out) phase.
REQ-011 nACK  output  1  SCSI ACK, active-low, registered.
REQ-012 nDBOut  output  8  inverted (active-low) SCSI data byte, registered.
REQ-013 dbDrive  output  1  high while nDBOut is to be driven onto the bidirectional SCSI bus.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 overrun  output  1  sticky; set when a host write is rejected.

Function
REQ-016 SHALL pass nREQ and nIO through SYNC_STAGES flops; sREQ and sIO below denote the synchronised values.
REQ-017 SHALL implement states IDLE, LOADED, SETUP, ACK and RELEASE.
REQ-018 IDLE: nWrite low SHALL latch hostData into the data register and enter LOADED next clock.
REQ-019 LOADED: sREQ low and sIO high SHALL enter SETUP; otherwise the block SHALL stay in LOADED indefinitely.
REQ-020 SETUP: dbDrive SHALL be high and nDBOut SHALL equal ~data; the block SHALL stay exactly SETUP_CYCLES clocks, then enter ACK.
REQ-021 ACK: nACK SHALL be low, dbDrive high and data held; the block SHALL stay until sREQ is high, then enter RELEASE.
REQ-022 RELEASE: nACK SHALL be high and dbDrive low for exactly one clock, then the block SHALL enter IDLE.
REQ-023 Outside SETUP and ACK, dbDrive SHALL be low and nDBOut SHALL be 8'h00, because the bus is internal and direction control is external.
REQ-024 nWrite low in any state other than IDLE SHALL discard the byte, leave the data register unchanged and set overrun on the next clock.
REQ-025 clrOverrun high SHALL clear overrun on the next clock; clrOverrun coinciding with a rejected write SHALL leave overrun set (set wins).
REQ-026 sIO falling while in LOADED SHALL keep the block in LOADED and not drive the bus; sIO change during SETUP or ACK SHALL NOT abort the handshake.
REQ-027 A write in IDLE with sREQ already low SHALL reach SETUP two clocks after the write (IDLE->LOADED->SETUP).
REQ-028 Latency from the write clock to nACK low SHALL be 2+SETUP_CYCLES clocks when sREQ is already low and sIO is high.
REQ-029 The SETUP counter SHALL be 4 bits, load on entry to SETUP and not wrap.

Reset
REQ-030 nReset low SHALL immediately force: state IDLE, nACK=1, dbDrive=0, nDBOut=8'h00, busy=0, overrun=0, data register=8'h00, synchronisers=1 (inactive).
REQ-031 Reset mid-handshake SHALL release nACK and the bus asynchronously, with no completion of the handshake.

Structure
REQ-032 The state encoding and reset/idle constants (8'h00 bus value, inactive level 1'b1) SHALL live in a shared package scsi_pkg.
REQ-033 The nREQ/nIO synchroniser SHALL be one sub-module, scsi_sync, parameterised by SYNC_STAGES and instantiated once per signal.

Verification
REQ-034 Reset mid-ACK: nReset low while nACK=0 -> nACK=1, dbDrive=0 and nDBOut=8'h00 with no clock edge required.
REQ-035 Normal transfer: write 8'hA5, nIO=1, nREQ low -> nDBOut=8'h5A and dbDrive=1; nACK low 6 clocks after the write (default parameters); nREQ high -> nACK high, then busy=0 one clock after RELEASE.
REQ-036 Overrun: write 8'h11, then write 8'h22 while LOADED -> overrun=1; nDBOut later shows 8'hEE.
REQ-037 Overrun precedence: clrOverrun together with a rejected write -> overrun stays 1; clrOverrun alone -> overrun=0.
REQ-038 Wrong phase: write 8'h3C with nIO=0 and nREQ low -> stays LOADED with dbDrive=0; raise nIO -> transfer completes with nDBOut=8'hC3.
